// File: rtl/axi_lite_write_slave.sv
// rtl/axi_lite_write_slave.sv - AXI4-Lite write-channel responder with a 4-word register file
module axi_lite_write_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            s_aclk,
    input  logic                            s_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_awaddr,
    input  logic [2:0]                      s_awprot,
    input  logic                            s_awvalid,
    output logic                            s_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                            s_wvalid,
    output logic                            s_wready,
    output logic [1:0]                      s_bresp,
    output logic                            s_bvalid,
    input  logic                            s_bready,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0] regs_out
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int NB = DW / 8;

    // run holds both readies low for the first cycle after reset release
    logic          run;
    logic          aw_full;
    logic          w_full;
    logic [1:0]    aw_idx;
    logic [DW-1:0] w_data;
    logic [NB-1:0] w_strb;
    logic [DW-1:0] regs [4];

    logic          aw_hs;
    logic          w_hs;
    logic          commit;

    // Protection bits and the byte offset within a word carry no meaning here
    logic          unused_inputs;
    assign unused_inputs = ^{s_awprot, s_awaddr};

    // Each channel is single-slot; nothing new is taken while a response is pending
    assign s_awready = run & ~aw_full & ~s_bvalid;
    assign s_wready  = run & ~w_full  & ~s_bvalid;

    assign aw_hs  = s_awvalid & s_awready;
    assign w_hs   = s_wvalid  & s_wready;
    assign commit = aw_full & w_full & ~s_bvalid;

    // Capture AW/W independently, commit once both are held, then hold B until accepted
    always_ff @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            run      <= 1'b0;
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            aw_idx   <= '0;
            w_data   <= '0;
            w_strb   <= '0;
            s_bvalid <= 1'b0;
            s_bresp  <= 2'b00;
            for (int k = 0; k < 4; k++) begin
                regs[k] <= '0;
            end
        end else begin
            run <= 1'b1;

            if (aw_hs) begin
                aw_idx  <= s_awaddr[3:2];
                aw_full <= 1'b1;
            end

            if (w_hs) begin
                w_data <= s_wdata;
                w_strb <= s_wstrb;
                w_full <= 1'b1;
            end

            // A commit needs both slots full, so it never coincides with a new capture
            if (commit) begin
                for (int i = 0; i < NB; i++) begin
                    if (w_strb[i]) begin
                        regs[aw_idx][8*i +: 8] <= w_data[8*i +: 8];
                    end
                end
                aw_full  <= 1'b0;
                w_full   <= 1'b0;
                s_bvalid <= 1'b1;
                s_bresp  <= 2'b00;
            end else if (s_bvalid && s_bready) begin
                s_bvalid <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_regs_out
        assign regs_out[k*DW +: DW] = regs[k];
    end

endmodule

// File: tb/tb_axi_lite_write_slave.sv
// tb/tb_axi_lite_write_slave.sv - randomized and directed bench for axi_lite_write_slave
module tb_axi_lite_write_slave;

    logic         s_aclk = 1'b0;
    logic         s_aresetn;
    logic [3:0]   s_awaddr;
    logic [2:0]   s_awprot;
    logic         s_awvalid;
    logic         s_awready;
    logic [31:0]  s_wdata;
    logic [3:0]   s_wstrb;
    logic         s_wvalid;
    logic         s_wready;
    logic [1:0]   s_bresp;
    logic         s_bvalid;
    logic         s_bready;
    logic [127:0] regs_out;

    int checks = 0;
    int passed = 0;
    bit chk_en = 0;

    always #5 s_aclk = ~s_aclk;

    axi_lite_write_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4)
    ) dut (
        .s_aclk    (s_aclk),
        .s_aresetn (s_aresetn),
        .s_awaddr  (s_awaddr),
        .s_awprot  (s_awprot),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .regs_out  (regs_out)
    );

    // Transaction-level model: pending addresses and data sit in queues until paired
    logic [31:0] m_regs [4] = '{default: 32'h0};
    int          aw_q [$];
    logic [35:0] w_q [$];
    bit          m_run = 0;
    bit          m_bpend = 0;
    bit          aw_hs_last = 0;
    bit          w_hs_last = 0;
    int          m_commits = 0;
    bit          m_aw_rdy, m_w_rdy, m_pair;
    int          m_idx;
    logic [35:0] m_w;

    function automatic bit exp_awready();
        return m_run && (aw_q.size() == 0) && !m_bpend;
    endfunction

    function automatic bit exp_wready();
        return m_run && (w_q.size() == 0) && !m_bpend;
    endfunction

    always @(posedge s_aclk or negedge s_aresetn) begin
        if (!s_aresetn) begin
            for (int k = 0; k < 4; k++) m_regs[k] = 32'h0;
            aw_q.delete();
            w_q.delete();
            m_run = 0;
            m_bpend = 0;
            aw_hs_last = 0;
            w_hs_last = 0;
        end else begin
            m_aw_rdy   = exp_awready();
            m_w_rdy    = exp_wready();
            m_pair     = (aw_q.size() > 0) && (w_q.size() > 0) && !m_bpend;
            aw_hs_last = m_aw_rdy && s_awvalid;
            w_hs_last  = m_w_rdy && s_wvalid;
            if (m_pair) begin
                m_idx = aw_q.pop_front();
                m_w   = w_q.pop_front();
                for (int l = 0; l < 4; l++)
                    if (m_w[32+l]) m_regs[m_idx][8*l +: 8] = m_w[8*l +: 8];
                m_bpend = 1;
                m_commits++;
            end else if (m_bpend && s_bready) begin
                m_bpend = 0;
            end
            if (aw_hs_last) aw_q.push_back(int'(s_awaddr[3:2]));
            if (w_hs_last) w_q.push_back({s_wstrb, s_wdata});
            m_run = 1;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    // Every falling edge: all DUT outputs must match the model
    always @(negedge s_aclk) begin
        if (chk_en) begin
            check("awready", 128'(s_awready), 128'(exp_awready()));
            check("wready", 128'(s_wready), 128'(exp_wready()));
            check("bvalid", 128'(s_bvalid), 128'(m_bpend));
            check("bresp", 128'(s_bresp), 128'(2'b00));
            check("regs_out", regs_out, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
        end
    end

    task automatic tick();
        @(posedge s_aclk);
        #1;
    endtask

    task automatic send(input bit do_aw, input bit do_w, input logic [3:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        s_awvalid = do_aw;
        s_awaddr  = a;
        s_wvalid  = do_w;
        s_wdata   = d;
        s_wstrb   = s;
        while (s_awvalid || s_wvalid) begin
            tick();
            if (aw_hs_last) s_awvalid = 1'b0;
            if (w_hs_last) s_wvalid = 1'b0;
            n++;
            if (n > 50) begin
                checks++;
                $display("FAIL handshake_timeout: got no handshake after %0d cycles expected one", n);
                s_awvalid = 1'b0;
                s_wvalid  = 1'b0;
            end
        end
    endtask

    initial begin
        s_aresetn = 1'b0;
        s_awaddr  = '0;
        s_awprot  = '0;
        s_awvalid = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b1;
        tick();
        tick();
        chk_en = 1;
        check("reset_regs", regs_out, 128'h0);
        check("reset_awready", 128'(s_awready), 128'h0);
        s_aresetn = 1'b1;
        tick();
        tick();

        // Same-cycle AW/W
        send(1, 1, 4'h8, 32'hDEADBEEF, 4'hF);
        tick();
        check("t1_bvalid", 128'(s_bvalid), 128'h1);
        check("t1_reg2", 128'(regs_out[95:64]), 128'hDEADBEEF);
        check("t1_model_reg2", 128'(m_regs[2]), 128'hDEADBEEF);
        tick();
        check("t1_bvalid_drop", 128'(s_bvalid), 128'h0);

        // AW first, W three cycles later
        send(1, 0, 4'h4, 32'h0, 4'h0);
        check("t2_awready_wait", 128'(s_awready), 128'h0);
        repeat (3) tick();
        send(0, 1, 4'h0, 32'h12345678, 4'hF);
        check("t2_reg1_before", 128'(regs_out[63:32]), 128'h0);
        tick();
        check("t2_reg1", 128'(regs_out[63:32]), 128'h12345678);
        tick();

        // W first, AW five cycles later
        send(0, 1, 4'h0, 32'hCAFEF00D, 4'hF);
        check("t3_wready_wait", 128'(s_wready), 128'h0);
        repeat (5) tick();
        send(1, 0, 4'hC, 32'h0, 4'h0);
        tick();
        check("t3_reg3", 128'(regs_out[127:96]), 128'hCAFEF00D);
        tick();

        // Partial strobes
        send(1, 1, 4'h0, 32'hFFFFFFFF, 4'hF);
        tick();
        tick();
        send(1, 1, 4'h1, 32'h00000000, 4'b0101);
        tick();
        check("t4_reg0", 128'(regs_out[31:0]), 128'hFF00FF00);
        tick();

        // Back-pressure on B
        s_bready = 1'b0;
        send(1, 1, 4'h4, 32'hAAAA5555, 4'hF);
        tick();
        s_awvalid = 1'b1;
        s_awaddr  = 4'h8;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t5_bvalid_hold", 128'(s_bvalid), 128'h1);
            check("t5_awready_hold", 128'(s_awready), 128'h0);
        end
        s_bready = 1'b1;
        tick();
        check("t5_bvalid_done", 128'(s_bvalid), 128'h0);
        check("t5_awready_free", 128'(s_awready), 128'h1);
        tick();
        s_awvalid = 1'b0;
        check("t5_aw_taken", 128'(s_awready), 128'h0);
        send(0, 1, 4'h0, 32'h11112222, 4'hF);
        tick();
        check("t5_reg2", 128'(regs_out[95:64]), 128'h11112222);
        tick();

        // Reset between AW and W
        send(1, 0, 4'hC, 32'h0, 4'h0);
        #2 s_aresetn = 1'b0;
        #1;
        check("t6_regs_cleared", regs_out, 128'h0);
        check("t6_bvalid", 128'(s_bvalid), 128'h0);
        tick();
        s_aresetn = 1'b1;
        tick();
        send(0, 1, 4'h0, 32'h55AA55AA, 4'hF);
        tick();
        tick();
        check("t6_no_stale_commit", 128'(s_bvalid), 128'h0);
        send(1, 0, 4'h4, 32'h0, 4'h0);
        tick();
        check("t6_reg1", 128'(regs_out[63:32]), 128'h55AA55AA);
        check("t6_reg3_clear", 128'(regs_out[127:96]), 128'h0);
        tick();

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            if (!s_awvalid || aw_hs_last) begin
                s_awvalid = ($urandom_range(0, 2) != 0);
                s_awaddr  = 4'($urandom);
                s_awprot  = 3'($urandom);
            end
            if (!s_wvalid || w_hs_last) begin
                s_wvalid = ($urandom_range(0, 2) != 0);
                s_wdata  = $urandom;
                s_wstrb  = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
            end
            s_bready = ($urandom_range(0, 2) != 0);
            if (!s_aresetn) s_aresetn = 1'b1;
            else if ($urandom_range(0, 399) == 0) s_aresetn = 1'b0;
            tick();
        end
        s_aresetn = 1'b1;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b1;
        repeat (4) tick();
        check("random_commits_seen", 128'(m_commits > 200), 128'h1);

        chk_en = 0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
